// File: rtl/tb_doutb_router.sv
// Temp-buffer port-B read-out engine: command-driven read bursts, per-word lane
// mapping (forward / reversed / zero with rotation) and steering to one destination.
module tb_doutb_router #(
   parameter  int L      = 4,
   parameter  int Y      = 4,
   parameter  int RSA_DW = 16,
   parameter  int N_DST  = 2,
   parameter  int ADDR_W = 8,
   parameter  int LEN_W  = 6,
   parameter  int OFS_W  = 2,
   localparam int DST_W  = (N_DST > 1) ? $clog2(N_DST) : 1
) (
   input  logic                      clk,
   input  logic                      sys_rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [DST_W-1:0]          cmd_dst,
   input  logic [1:0]                cmd_map,
   input  logic                      cmd_desc,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [LEN_W-1:0]          cmd_len,
   input  logic [OFS_W-1:0]          cmd_ofs,
   output logic                      TB_enb,
   output logic [ADDR_W-1:0]         TB_addrb,
   input  logic [L*RSA_DW-1:0]       TB_doutb,
   output logic [N_DST*Y*RSA_DW-1:0] dst_dout,
   output logic [N_DST-1:0]          dst_valid,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] MAP_POS = 2'b01;
   localparam logic [1:0] MAP_NEG = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                    state_reg, state_next;
   logic [ADDR_W-1:0]         cnt_reg, cnt_next;
   logic [LEN_W-1:0]          rem_reg, rem_next;
   logic [DST_W-1:0]          dst_reg, dst_next;
   logic [1:0]                map_reg, map_next;
   logic                      desc_reg, desc_next;
   logic [OFS_W-1:0]          ofs_reg, ofs_next;
   logic                      done_reg, done_next;
   logic                      rd_vld_reg;
   logic [N_DST-1:0]          valid_reg, valid_next;
   logic [N_DST*Y*RSA_DW-1:0] dout_reg, dout_next;

   logic [RSA_DW-1:0]         in_lane [L];
   logic [Y*RSA_DW-1:0]       mapped;

   // Command control: the offset is reduced modulo L once at acceptance.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rem_next   = rem_reg;
      dst_next   = dst_reg;
      map_next   = map_reg;
      desc_next  = desc_reg;
      ofs_next   = ofs_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               dst_next   = cmd_dst;
               map_next   = cmd_map;
               desc_next  = cmd_desc;
               ofs_next   = OFS_W'(int'(cmd_ofs) % L);
               cnt_next   = cmd_addr;
               rem_next   = cmd_len;
               state_next = (cmd_len != '0) ? READ : DRAIN;
            end
         end
         READ: begin
            cnt_next = desc_reg ? cnt_reg - ADDR_W'(1) : cnt_reg + ADDR_W'(1);
            rem_next = rem_reg - LEN_W'(1);
            if (rem_reg == LEN_W'(1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // The done cycle is spent in DRAIN so no command can be taken alongside it.
            if (done_reg) begin
               state_next = IDLE;
            end else if (!rd_vld_reg) begin
               done_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_in_lane
         assign in_lane[gi] = TB_doutb[gi*RSA_DW +: RSA_DW];
      end
   endgenerate

   always_comb begin
      mapped = '0;
      for (int i = 0; i < Y; i++) begin
         for (int k = 0; k < L; k++) begin
            if (ofs_reg == OFS_W'(k)) begin
               if (map_reg == MAP_POS) begin
                  mapped[i*RSA_DW +: RSA_DW] = in_lane[(i + k) % L];
               end else if (map_reg == MAP_NEG) begin
                  mapped[i*RSA_DW +: RSA_DW] = in_lane[(2*L - 1 - i - k) % L];
               end
            end
         end
      end
   end

   // Unselected slices (and an out-of-range destination) see zeros and no valid.
   generate
      for (gi = 0; gi < N_DST; gi++) begin : g_dst
         assign valid_next[gi] = rd_vld_reg && (int'(dst_reg) == gi);
         assign dout_next[gi*Y*RSA_DW +: Y*RSA_DW] = valid_next[gi] ? mapped : '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         dst_reg    <= '0;
         map_reg    <= '0;
         desc_reg   <= 1'b0;
         ofs_reg    <= '0;
         done_reg   <= 1'b0;
         rd_vld_reg <= 1'b0;
         valid_reg  <= '0;
         dout_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         rem_reg    <= rem_next;
         dst_reg    <= dst_next;
         map_reg    <= map_next;
         desc_reg   <= desc_next;
         ofs_reg    <= ofs_next;
         done_reg   <= done_next;
         rd_vld_reg <= (state_reg == READ);
         valid_reg  <= valid_next;
         dout_reg   <= dout_next;
      end
   end

   assign cmd_ready = (state_reg == IDLE) && !sys_rst;
   assign TB_enb    = (state_reg == READ);
   assign TB_addrb  = TB_enb ? cnt_reg : '0;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign dst_dout  = dout_reg;
   assign dst_valid = valid_reg;

endmodule

// File: tb/tb_tb_doutb_router.sv
// Randomized bench for tb_doutb_router: a cycle-indexed expectation table built from
// each accepted command is compared against every DUT output on every cycle.
module tb_tb_doutb_router;

   localparam int L    = 4;
   localparam int Y    = 4;
   localparam int DW   = 16;
   localparam int ND   = 3;
   localparam int AW   = 8;
   localparam int LW   = 6;
   localparam int OW   = 2;
   localparam int DSTW = 2;
   localparam int TBW  = L*DW;
   localparam int OUTW = ND*Y*DW;
   localparam int NC   = 6000;

   logic            clk = 1'b0;
   logic            sys_rst = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [DSTW-1:0] cmd_dst = '0;
   logic [1:0]      cmd_map = '0;
   logic            cmd_desc = 1'b0;
   logic [AW-1:0]   cmd_addr = '0;
   logic [LW-1:0]   cmd_len = '0;
   logic [OW-1:0]   cmd_ofs = '0;
   logic            TB_enb;
   logic [AW-1:0]   TB_addrb;
   logic [TBW-1:0]  TB_doutb = '0;
   logic [OUTW-1:0] dst_dout;
   logic [ND-1:0]   dst_valid;
   logic            busy;
   logic            done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic            e_enb  [NC];
   logic [AW-1:0]   e_addr [NC];
   logic [ND-1:0]   e_val  [NC];
   logic [OUTW-1:0] e_dout [NC];
   logic            e_done [NC];
   logic            e_busy [NC];

   tb_doutb_router #(.L(L), .Y(Y), .RSA_DW(DW), .N_DST(ND), .ADDR_W(AW), .LEN_W(LW), .OFS_W(OW)) dut (
      .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dst(cmd_dst), .cmd_map(cmd_map), .cmd_desc(cmd_desc), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_ofs(cmd_ofs), .TB_enb(TB_enb), .TB_addrb(TB_addrb),
      .TB_doutb(TB_doutb), .dst_dout(dst_dout), .dst_valid(dst_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // TB contents: lane j of address a holds 16*a + j.
   function automatic logic [TBW-1:0] tb_word(input logic [AW-1:0] a);
      logic [TBW-1:0] w;
      for (int j = 0; j < L; j++) w[j*DW +: DW] = DW'(int'(a) * 16 + j);
      return w;
   endfunction

   // Read-only memory with one cycle of latency; garbage when not enabled.
   always @(posedge clk) begin
      TB_doutb <= TB_enb ? tb_word(TB_addrb) : {$urandom, $urandom};
   end

   function automatic logic [Y*DW-1:0] model_map(input logic [TBW-1:0] w, input int m, input int o);
      logic [Y*DW-1:0] r;
      int src;
      r = '0;
      for (int i = 0; i < Y; i++) begin
         if (m == 1 || m == 2) begin
            if (m == 1) src = (i + o) % L;
            else begin
               src = (L - 1 - i - o) % L;
               if (src < 0) src += L;
            end
            r[i*DW +: DW] = w[src*DW +: DW];
         end
      end
      return r;
   endfunction

   function automatic logic [AW-1:0] addr_at(input logic [AW-1:0] a, input logic desc, input int k);
      return desc ? AW'(int'(a) - k) : AW'(int'(a) + k);
   endfunction

   task automatic chk(input string nm, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic clear_from(input int c0, input int c1);
      for (int c = c0; c <= c1 && c < NC; c++) begin
         e_enb[c] = 1'b0; e_addr[c] = '0; e_val[c] = '0;
         e_dout[c] = '0; e_done[c] = 1'b0; e_busy[c] = 1'b0;
      end
   endtask

   task automatic schedule(input int c);
      int dc, t, d, len;
      logic [AW-1:0] a;
      logic [OUTW-1:0] tmp;
      d = int'(cmd_dst);
      len = int'(cmd_len);
      dc = (len == 0) ? c + 2 : c + len + 3;
      $display("cmd @%0d dst=%0d map=%0d desc=%0d addr=%02h len=%0d ofs=%0d",
               c, d, cmd_map, cmd_desc, cmd_addr, len, cmd_ofs);
      for (int k = c + 1; k <= dc; k++) e_busy[k] = 1'b1;
      e_done[dc] = 1'b1;
      for (int k = 0; k < len; k++) begin
         t = c + 1 + k;
         a = addr_at(cmd_addr, cmd_desc, k);
         e_enb[t] = 1'b1;
         e_addr[t] = a;
         if (d < ND) begin
            e_val[t+2][d] = 1'b1;
            tmp = e_dout[t+2];
            tmp[d*Y*DW +: Y*DW] = model_map(tb_word(a), int'(cmd_map), int'(cmd_ofs));
            e_dout[t+2] = tmp;
         end
      end
   endtask

   // Compare process, then advance the model with what this cycle's edge will see.
   initial begin
      logic rst_prev;
      logic exp_ready;
      rst_prev = 1'b0;
      clear_from(0, NC - 1);
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc < NC - 100) begin
            exp_ready = !sys_rst && !e_busy[cyc];
            if (sys_rst && !rst_prev) begin
               chk("ready_in_reset", cmd_ready, 0);
            end else begin
               chk("cmd_ready", cmd_ready, exp_ready);
               chk("busy", busy, e_busy[cyc]);
               chk("TB_enb", TB_enb, e_enb[cyc]);
               chk("TB_addrb", TB_addrb, e_addr[cyc]);
               chk("dst_valid", dst_valid, e_val[cyc]);
               chk("dst_dout", dst_dout, e_dout[cyc]);
               chk("done", done, e_done[cyc]);
            end
            if (sys_rst) clear_from(cyc + 1, cyc + 99);
            else if (cmd_valid && exp_ready) schedule(cyc);
            rst_prev = sys_rst;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int d, input int m, input int ds, input int a, input int n, input int o);
      cmd_dst = DSTW'(d); cmd_map = 2'(m); cmd_desc = 1'(ds);
      cmd_addr = AW'(a); cmd_len = LW'(n); cmd_ofs = OW'(o);
   endtask

   task automatic wait_accept();
      int n;
      n = 0;
      while (!cmd_ready && n < 300) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout cycle %0d: got ready=0 expected ready=1", cyc);
      end
      tick();
   endtask

   task automatic send(input int d, input int m, input int ds, input int a, input int n, input int o);
      set_cmd(d, m, ds, a, n, o);
      cmd_valid = 1'b1;
      wait_accept();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || !cmd_ready) && n < 300) begin
         tick();
         n++;
      end
      if (busy || !cmd_ready) begin
         vectors++; miscompares++;
         $display("FAIL idle_timeout cycle %0d: got busy=%0d expected busy=0", cyc, busy);
      end
   endtask

   initial begin
      logic [TBW-1:0] w;
      w = {16'd13, 16'd12, 16'd11, 16'd10};
      repeat (3) tick();
      sys_rst = 1'b0;
      tick();

      // Hand-computed expectations that pin the reference model.
      chk("pin_neg_ofs1", model_map(w, 2, 1), {16'd13, 16'd10, 16'd11, 16'd12});
      chk("pin_pos_ofs3", model_map(w, 1, 3), {16'd12, 16'd11, 16'd10, 16'd13});
      chk("pin_pos_ofs0", model_map(w, 1, 0), w);
      chk("pin_map11_zero", model_map(w, 3, 2), 0);
      chk("pin_addr_wrap2", addr_at(8'h01, 1'b1, 2), 8'hFF);
      chk("pin_addr_wrap3", addr_at(8'h01, 1'b1, 3), 8'hFE);
      chk("pin_tb_word", tb_word(8'h10), {16'h0103, 16'h0102, 16'h0101, 16'h0100});

      send(0, 1, 0, 8'h10, 3, 0); wait_idle();
      send(1, 2, 0, 8'h20, 2, 1); wait_idle();
      send(2, 1, 0, 8'h30, 2, 3); wait_idle();
      send(0, 0, 1, 8'h01, 4, 0); wait_idle();
      send(1, 3, 0, 8'hFE, 3, 1); wait_idle();
      send(1, 1, 0, 8'h40, 0, 0); wait_idle();

      // Valid held through a burst while the fields change underneath it.
      set_cmd(2, 2, 1, 8'h80, 5, 2);
      cmd_valid = 1'b1;
      wait_accept();
      set_cmd(0, 1, 0, 8'h90, 3, 1);
      wait_accept();
      cmd_valid = 1'b0;
      wait_idle();

      send(3, 1, 0, 8'h50, 3, 0); wait_idle();

      send(0, 1, 0, 8'h60, 20, 2);
      repeat (5) tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      send(1, 2, 1, 8'h05, 4, 3); wait_idle();

      for (int n = 0; n < 60; n++) begin
         int len;
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 10);
         send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 255), len, $urandom_range(0, 3));
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 14) == 0) begin
            sys_rst = 1'b1;
            repeat ($urandom_range(1, 2)) tick();
            sys_rst = 1'b0;
         end
      end
      wait_idle();
      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #(NC * 10);
      vectors++; miscompares++;
      $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tb_doutb_router.md
Name: tb_doutb_router

Overview:
- Command-driven read-out engine for one temp-buffer (TB) port-B.
- Per command, issues a burst of consecutive TB reads and lane-maps each returned word: forward, reversed, or zero, with a lane rotation offset.
- Steers the mapped word to one of N_DST systolic-array operand destinations (B, B_cache, ...).
- Parametrised, sequenced replacement for the fixed two-destination, single-word TB port-B output mapper.

Parameters:
L, 4, TB word lanes
Y, 4, destination lanes per word (Y <= L)
RSA_DW, 16, lane width in bits
N_DST, 2, number of destinations
ADDR_W, 8, TB address width
LEN_W, 6, burst length width
OFS_W, 2, lane offset width (2^OFS_W >= L)

Ports:
clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept a command
cmd_dst  in  clog2(N_DST) (min 1)  destination index
cmd_map  in  2  00 ZERO, 01 POS, 10 NEG, 11 ZERO
cmd_desc  in  1  0 addresses ascend, 1 addresses descend
cmd_addr  in  ADDR_W  first TB address
cmd_len  in  LEN_W  number of words
cmd_ofs  in  OFS_W  lane rotation offset
TB_enb  out  1  TB port-B read enable
TB_addrb  out  ADDR_W  TB port-B address
TB_doutb  in  L*RSA_DW  TB read data, valid 1 cycle after TB_enb
dst_dout  out  N_DST*Y*RSA_DW  per-destination mapped word; destination d occupies slice d*Y*RSA_DW
dst_valid  out  N_DST  per-destination word valid
busy  out  1  command in progress
done  out  1  one-cycle pulse at end of command

Behaviour:
- Interface: single clock clk; reset sys_rst is synchronous and active-high.
- Reset:
  - All outputs 0: cmd_ready=0 during reset, 1 in the first cycle after it.
  - FSM goes to IDLE; pipeline valids are cleared.
  - Reset mid-burst aborts the command. In-flight data is discarded and no done pulse is issued.
- FSM states IDLE, READ, DRAIN:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid, latch dst/map/desc/ofs, load the address counter from cmd_addr and the remaining count from cmd_len.
    - If cmd_len!=0, go to READ. If cmd_len=0, go to DRAIN with nothing in flight.
  - READ:
    - TB_enb=1 each cycle; TB_addrb = counter value.
    - Counter steps +1 (desc=0) or -1 (desc=1) modulo 2^ADDR_W; wrap is legal and silent.
    - Remaining count decrements each cycle; after the last issue, go to DRAIN.
  - DRAIN: wait until the pipeline is empty. Then pulse done for one cycle and return to IDLE.
- Handshakes and status:
  - cmd_ready=0 in READ and DRAIN; commands offered then are not accepted.
  - busy=1 in READ and DRAIN.
- Pipeline: TB_enb at cycle t -> TB_doutb valid at t+1 -> mapped word registered onto dst_dout/dst_valid at t+2. Throughput is one word per cycle, gapless.
- Lane map, per output lane i in [0,Y), with o=latched ofs:
  - POS: out[i] = in[(i+o) mod L].
  - NEG: out[i] = in[(L-1-i-o) mod L]. Arithmetic is modulo L, not 2^OFS_W.
  - ZERO / 11: out = 0, but dst_valid still pulses (zero-fill words).
- Destination steering:
  - Only slice cmd_dst is updated and only dst_valid[cmd_dst] pulses.
  - Non-selected slices are driven 0 whenever any word is output.
  - With no valid word, all dst_dout = 0 and dst_valid = 0.
  - cmd_dst >= N_DST: reads still occur, no dst_valid asserts, done still pulses.
- done timing:
  - done coincides with the cycle after the last dst_valid.
  - For len=0, done asserts 2 cycles after acceptance (IDLE->DRAIN->done).
- Back-to-back commands:
  - The earliest next acceptance is the cycle after done; no overlap between commands.
  - Latched command fields are stable for the whole burst.

Test Plan:
- Reset then cmd dst=0, map=POS, ofs=0, addr=0x10, len=3, TB returns lanes {3,2,1,0}+16*addr -> TB_addrb 0x10,0x11,0x12 on 3 consecutive cycles; dst_valid[0] high 3 cycles starting 2 cycles after first TB_enb; slice0 equals TB_doutb; slice1 = 0; single done pulse.
- map=NEG, ofs=1, L=Y=4, input lanes [a0,a1,a2,a3] -> output lanes [a2,a1,a0,a3]; map=POS, ofs=3 -> [a3,a0,a1,a2].
- desc=1, addr=0x01, len=4 -> addresses 0x01,0x00,0xFF,0xFE; map=ZERO -> 4 dst_valid pulses, all-zero data.
- len=0 -> no TB_enb, no dst_valid, done exactly 2 cycles after acceptance; cmd_ready low until done.
- cmd_valid held high during a burst -> second command accepted only in the cycle after done; cmd_dst=N_DST -> reads issued, no dst_valid, done pulses.
- sys_rst asserted mid-READ -> next cycle all outputs 0, no done; new command afterwards runs cleanly with no stale words.
